lerp_pipe: RTL



---
 rtl/lerp_pkg.sv | 21 ++
 rtl/lerp_pipe_stage.sv | 32 +++
 rtl/lerp_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lerp_pkg.sv
// Shared types and width helpers for the lerp_pipe interpolator.
package lerp_pkg;

  // Encoding 3 is reserved and behaves like HOLD.
  typedef enum logic [1:0] {
    LINEAR  = 2'd0,
    NEAREST = 2'd1,
    HOLD    = 2'd2
  } mode_t;

  // Width of the signed product (b-a)*ratio. |b-a| < 2^n and ratio < 2^r,
  // so n+r magnitude bits plus a sign bit always suffice.
  function automatic int prod_width(input int input_bits, input int ratio_bits);
    return input_bits + ratio_bits + 1;
  endfunction

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/lerp_pipe_stage.sv
// Enable-gated valid + payload pipeline register with asynchronous active-low clear.
module lerp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // NOTE: the payload is cleared along with the valid bit so the block's
  // outputs read as zero out of reset, not just as invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/lerp_pipe.sv
// Three-stage tagged linear interpolator: out = a + floor((b-a)*ratio / 2^R),
// with per-sample LINEAR / NEAREST / HOLD selection and a single global stall.
module lerp_pipe
  import lerp_pkg::*;
#(
  parameter  int INPUT_BITS      = 16,
  parameter  int RATIO_FRAC_BITS = 8,
  parameter  int CHANNELS        = 8,
  localparam int CW              = chan_width(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INPUT_BITS-1:0]      in_a,
  input  logic [INPUT_BITS-1:0]      in_b,
  input  logic [RATIO_FRAC_BITS-1:0] in_ratio,
  input  logic [CW-1:0]              in_chan,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INPUT_BITS-1:0]      out_data,
  output logic [CW-1:0]              out_chan
);

  localparam int N  = INPUT_BITS;
  localparam int R  = RATIO_FRAC_BITS;
  localparam int PW = prod_width(N, R);

  typedef struct packed {
    logic [N-1:0]        a;
    logic [N-1:0]        b;
    logic [R-1:0]        ratio;
    logic [CW-1:0]       chan;
    logic [1:0]          mode;
    logic signed [N:0]   diff;
  } s1_t;

  typedef struct packed {
    logic [N-1:0]        a;
    logic [N-1:0]        b;
    logic                near_b;
    logic [CW-1:0]       chan;
    logic [1:0]          mode;
    logic signed [PW-1:0] prod;
  } s2_t;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [CW-1:0] chan;
  } s3_t;

  logic en;
  logic s1_valid, s2_valid, s3_valid;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;

  logic signed [PW-1:0] diff_ext;
  logic signed [PW-1:0] ratio_ext;
  logic signed [PW-1:0] prod_s;
  logic [N-1:0]         lerp_term;
  logic [N-1:0]         lerp_sum;

  // Every stage moves together; a full pipe stalls only while the head is blocked.
  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // Stage 1: capture inputs and form the signed difference b - a.
  always_comb begin
    s1_d       = '0;
    s1_d.a     = in_a;
    s1_d.b     = in_b;
    s1_d.ratio = in_ratio;
    s1_d.chan  = in_chan;
    s1_d.mode  = in_mode;
    s1_d.diff  = $signed({1'b0, in_b}) - $signed({1'b0, in_a});
  end

  lerp_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .valid_i (in_valid),
    .data_i  (s1_d),
    .valid_o (s1_valid),
    .data_o  (s1_q)
  );

  // Stage 2: diff * ratio with ratio treated as a non-negative fraction.
  assign diff_ext  = {{(PW-N-1){s1_q.diff[N]}}, s1_q.diff};
  assign ratio_ext = {{(PW-R){1'b0}}, s1_q.ratio};

  always_comb begin
    s2_d        = '0;
    s2_d.a      = s1_q.a;
    s2_d.b      = s1_q.b;
    s2_d.near_b = s1_q.ratio[R-1];
    s2_d.chan   = s1_q.chan;
    s2_d.mode   = s1_q.mode;
    s2_d.prod   = diff_ext * ratio_ext;
  end

  lerp_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .valid_i (s1_valid),
    .data_i  (s2_d),
    .valid_o (s2_valid),
    .data_o  (s2_q)
  );

  // Stage 3: arithmetic shift floors toward -inf; the wrap-around add lands
  // back inside [min(a,b), max(a,b)] so no saturation is needed.
  assign prod_s    = s2_q.prod;
  assign lerp_term = N'(prod_s >>> R);
  assign lerp_sum  = s2_q.a + lerp_term;

  // NOTE: s3_d gets a full default before the case so no path leaves it
  // unassigned, which keeps this block purely combinational.
  always_comb begin
    s3_d      = '0;
    s3_d.chan = s2_q.chan;
    case (s2_q.mode)
      LINEAR:  s3_d.data = lerp_sum;
      NEAREST: s3_d.data = s2_q.near_b ? s2_q.b : s2_q.a;
      default: s3_d.data = s2_q.a;
    endcase
  end

  lerp_pipe_stage #(.W($bits(s3_t))) u_s3 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .valid_i (s2_valid),
    .data_i  (s3_d),
    .valid_o (s3_valid),
    .data_o  (s3_q)
  );

  assign out_valid = s3_valid;
  assign out_data  = s3_q.data;
  assign out_chan  = s3_q.chan;

endmodule
